// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM state encodings and the default frame start marker.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    LD_IDLE, LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CHECK, LD_DONE, LD_ERR
  } ld_state_e;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream in, instruction-memory writes and core release out.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              core_rst_n;
  logic              load_done;
  logic              load_error;
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, load_done, load_error
  );
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, load_done, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: parses SYNC/LEN/words/CHK frames into instruction-memory writes and
// holds the core in reset until a checksum-verified image is loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  ld_state_e       state, nstate;
  logic [15:0]     len, len_nx;
  logic [ADDR_W:0] cnt;
  logic [7:0]      chk, hi, d;
  logic            xfer, sync, last;
  assign bus.rx_ready = 1'b1;
  assign xfer   = bus.rx_valid;
  assign d      = bus.rx_data;
  assign sync   = d == SYNC_BYTE;
  assign len_nx = {len[15:8], d};
  // counter is one bit wider than the address so a full-capacity LEN terminates cleanly
  assign last   = 17'(cnt) + 17'd1 == 17'(len);
  always_comb begin
    nstate = state;
    if (xfer)
      case (state)
        LD_IDLE, LD_DONE, LD_ERR: nstate = sync ? LD_LEN_HI : state;
        LD_LEN_HI:  nstate = LD_LEN_LO;
        LD_LEN_LO:  nstate = 17'(len_nx) > CAP ? LD_ERR : len_nx == 16'd0 ? LD_CHECK : LD_DATA_HI;
        LD_DATA_HI: nstate = LD_DATA_LO;
        LD_DATA_LO: nstate = last ? LD_CHECK : LD_DATA_HI;
        LD_CHECK:   nstate = d == chk ? LD_DONE : LD_ERR;
        default:    nstate = LD_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LD_IDLE;
    else        state <= nstate;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len            <= '0;
      cnt            <= '0;
      chk            <= '0;
      hi             <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.core_rst_n <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.imem_we <= xfer && state == LD_DATA_LO;
      if (xfer && state inside {LD_IDLE, LD_DONE, LD_ERR} && sync) begin
        chk            <= '0;
        cnt            <= '0;
        bus.core_rst_n <= 1'b0;
        bus.load_done  <= 1'b0;
        bus.load_error <= 1'b0;
      end
      if (xfer && state inside {LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO}) chk <= chk ^ d;
      if (xfer && state == LD_LEN_HI) len[15:8] <= d;
      if (xfer && state == LD_LEN_LO) len[7:0] <= d;
      if (xfer && state == LD_DATA_HI) hi <= d;
      if (xfer && state == LD_DATA_LO) begin
        bus.imem_addr  <= cnt[ADDR_W-1:0];
        bus.imem_wdata <= {hi, d};
        cnt            <= cnt + 1'b1;
      end
      if (state == LD_CHECK && nstate == LD_DONE) begin
        bus.load_done  <= 1'b1;
        bus.core_rst_n <= 1'b1;
      end
      if (state != LD_ERR && nstate == LD_ERR) bus.load_error <= 1'b1;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level model of expected writes and release levels, checked every cycle.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(8)) bus();
  imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int vectors = 0;
  int errors = 0;
  int we_count = 0;
  int wc;
  logic exp_core = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [23:0] exp_wr[$];
  logic [23:0] w_exp;
  logic [7:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic [15:0] words[256];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("core_rst_n", 32'(bus.core_rst_n), 32'(exp_core));
    chk("load_done", 32'(bus.load_done), 32'(exp_done));
    chk("load_error", 32'(bus.load_error), 32'(exp_err));
    if (bus.imem_we === 1'b1) begin
      we_count++;
      last_addr = bus.imem_addr;
      last_data = bus.imem_wdata;
      if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        w_exp = exp_wr.pop_front();
        chk("imem_addr", 32'(bus.imem_addr), 32'(w_exp[23:16]));
        chk("imem_wdata", 32'(bus.imem_wdata), 32'(w_exp[15:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit upd = 1'b0,
                           input bit d = 1'b0, input bit e = 1'b0, input bit c = 1'b0);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    if (upd) begin
      exp_done = d;
      exp_err  = e;
      exp_core = c;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  // Builds a frame from words[0..len-1]; the checksum rule and expected outcome come from the frame definition.
  task automatic send_frame(input int len, input bit bad);
    logic [15:0] l;
    logic [7:0] x;
    l = 16'(len);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    x = l[15:8] ^ l[7:0];
    send_byte(l[15:8]);
    if (len > 256) begin
      send_byte(l[7:0], 1'b1, 1'b0, 1'b1, 1'b0);
      return;
    end
    send_byte(l[7:0]);
    for (int i = 0; i < len; i++) begin
      exp_wr.push_back({8'(i), words[i]});
      x = x ^ words[i][15:8] ^ words[i][7:0];
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
    send_byte(bad ? x ^ 8'h01 : x, 1'b1, !bad, bad, !bad);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_we", 32'(bus.imem_we), 32'd0);
    chk("reset_addr", 32'(bus.imem_addr), 32'd0);
    chk("reset_wdata", 32'(bus.imem_wdata), 32'd0);
    // garbage ahead of the sync byte must be ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    send_frame(2, 1'b0);
    idle(2);
    chk("nominal_last_addr", 32'(last_addr), 32'd1);
    chk("nominal_last_data", 32'(last_data), 32'hABCD);
    chk("nominal_writes", 32'(we_count), 32'd2);
    chk("nominal_done", 32'(bus.load_done), 32'd1);
    send_frame(2, 1'b1);
    idle(2);
    chk("badchk_writes", 32'(we_count), 32'd4);
    chk("badchk_error", 32'(bus.load_error), 32'd1);
    chk("badchk_core", 32'(bus.core_rst_n), 32'd0);
    wc = we_count;
    send_frame(0, 1'b0);
    idle(2);
    chk("empty_writes", 32'(we_count), 32'(wc));
    chk("empty_done", 32'(bus.load_done), 32'd1);
    send_frame(257, 1'b0);
    idle(2);
    chk("oversize_writes", 32'(we_count), 32'(wc));
    chk("oversize_error", 32'(bus.load_error), 32'd1);
    for (int i = 0; i < 256; i++) words[i] = 16'(i);
    send_frame(256, 1'b0);
    idle(2);
    chk("full_writes", 32'(we_count - wc), 32'd256);
    chk("full_last_addr", 32'(last_addr), 32'd255);
    chk("full_last_data", 32'(last_data), 32'h00FF);
    chk("full_done", 32'(bus.load_done), 32'd1);
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    send_frame(2, 1'b0);
    idle(2);
    chk("reload_last_data", 32'(last_data), 32'hABCD);
    chk("reload_core", 32'(bus.core_rst_n), 32'd1);
    // abort after the high byte of word 1; outputs must clear without a clock edge
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    exp_wr.push_back({8'd0, 16'h1234});
    send_byte(8'h34);
    send_byte(8'hAB);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_core = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    #1;
    chk("async_we", 32'(bus.imem_we), 32'd0);
    chk("async_addr", 32'(bus.imem_addr), 32'd0);
    chk("async_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("async_core", 32'(bus.core_rst_n), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    words[0] = 16'h0F0F;
    words[1] = 16'hF0F0;
    send_frame(2, 1'b0);
    idle(2);
    chk("post_reset_last_addr", 32'(last_addr), 32'd1);
    chk("post_reset_last_data", 32'(last_data), 32'hF0F0);
    chk("post_reset_done", 32'(bus.load_done), 32'd1);
    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the 16-bit microRISC core. It takes a framed byte stream from a host link (UART receiver or JTAG bridge) and writes 16-bit instruction words into the IF-stage instruction memory. It holds the core in reset while loading and releases it only after a checksum-verified load, so real hardware gets the program the simulation bench gets from its hex file.

## Interface
- `ADDR_W`, default 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- `SYNC_BYTE`, default 8'hA5, frame start marker.
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts the byte this cycle; a byte transfers when `rx_valid && rx_ready`.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  16  instruction word.
- `core_rst_n`  out  1  active-low reset to `processor_top`; low while the loader has no verified image.
- `load_done`  out  1  level; the last frame loaded and verified.
- `load_error`  out  1  level; the last frame was rejected.

## Operation
- Frame, all multi-byte fields big-endian: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words as two bytes each (high byte first), then CHK.
- CHK is the XOR of LEN_HI, LEN_LO and every data byte. SYNC_BYTE is excluded.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- IDLE/DONE/ERR: accepting SYNC_BYTE goes to LEN_HI, clears the running checksum, clears the word counter, clears `load_done` and `load_error`, and drives `core_rst_n` low. Any other byte is consumed and ignored.
- LEN_HI → LEN_LO → length check:
  - LEN > 2^ADDR_W: go to ERR.
  - LEN == 0: go to CHECK.
  - Otherwise: go to DATA_HI.
- DATA_HI latches the high byte, then goes to DATA_LO.
- DATA_LO completes a word:
  - Write the word at the address equal to the word counter.
  - Increment the counter.
  - Go to CHECK when the counter reaches LEN, else back to DATA_HI.
- CHECK:
  - Received byte == running XOR: go to DONE, set `load_done`, set `core_rst_n` high.
  - Otherwise: go to ERR, set `load_error`, keep `core_rst_n` low.
- Words already written before an error stay in memory. There is no rollback; the core simply is not released.
- `rx_ready` is 1 in every state. The loader never back-pressures, and bytes advance the FSM only when transferred.
- Word counter is ADDR_W+1 bits so that LEN == 2^ADDR_W is legal. `imem_addr` is the low ADDR_W bits, and the last address written is 2^ADDR_W−1 with no wrap.
- A SYNC_BYTE value received mid-frame is treated as data or length, never as a restart.

## Timing
- Reset values: state IDLE, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_rst_n` 0, `load_done` 0, `load_error` 0, `rx_ready` 1.
- All outputs are registered except `rx_ready`, which is a constant 1.
- `imem_we` goes high in the cycle after the DATA_LO byte transfer, for exactly one cycle, with `imem_addr`/`imem_wdata` valid in the same cycle.
- `core_rst_n`, `load_done` and `load_error` update in the cycle after the CHK transfer.
- Back-to-back bytes (`rx_valid` held high) are accepted one per cycle with no bubbles.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). Any partial image is abandoned.
- `core_rst_n` deasserts synchronously to `clk`, which gives the core a clean reset release.

## Structure
- Shared package (or `defines.v` additions): state encodings `LD_IDLE`…`LD_ERR` and the default `SYNC_BYTE`.
- No sub-module is required. The top-level wrapper instantiates the loader next to a UART RX and gates `processor_top.rst_n` with `core_rst_n & rst_n`.

## Test plan
- Nominal load: A5 00 02 12 34 AB CD 42 → writes 0x1234@0 and 0xABCD@1. `load_done`=1 and `core_rst_n`=1 one cycle after 0x42; `load_error`=0.
- Bad checksum: the same frame ending in 0x43 → both writes still occur; `load_error`=1, `core_rst_n` stays 0, `load_done`=0.
- Empty and oversize length:
  - A5 00 00 00 → DONE with no `imem_we` pulse.
  - With ADDR_W=8, A5 01 01 → ERR right after LEN_LO, with no writes.
- Full capacity: A5 01 00 then 256 words whose value equals their index, then the correct CHK → last write is 0x00FF@255, `imem_addr` never wraps, and DONE.
- Garbage and reload:
  - Bytes 00 FF 5A before A5 are ignored.
  - After a DONE, a second A5 frame drops `core_rst_n` in the cycle after the A5 and reloads from address 0.
- Reset mid-frame: assert `rst_n` low after the DATA_HI byte of word 1 → all outputs go to reset values asynchronously. A subsequent full frame loads correctly.
